// File: rtl/alu_mc_pkg.sv
// Purpose : shared widths and opcode constants for the multi-cycle ALU.
// Latency : n/a (constants only).
// Backpressure: n/a.
package alu_mc_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ALU_OPRN_WIDTH = 6;

  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_ADD = 6'h01;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SUB = 6'h02;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_MUL = 6'h03;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SRL = 6'h04;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLL = 6'h05;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_AND = 6'h06;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_OR  = 6'h07;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_NOR = 6'h08;
  localparam logic [ALU_OPRN_WIDTH-1:0] ALU_OPRN_SLT = 6'h09;

endpackage

// File: rtl/alu_mc_mult.sv
// Purpose : iterative shift-add multiplier, low DATA_WIDTH bits of the product.
// Latency : DATA_WIDTH iterations; the first runs on the start edge, done pulses after the last.
// Backpressure: none; a new start restarts the sequence, the caller guarantees one op in flight.
//
// Ports: clk, rst_n (sync, active-low), start (load operands + first step),
//        multiplicand/multiplier (sampled on start), busy, done (1-cycle pulse),
//        product (valid while done is high, held until the next start).
module mult_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] multiplicand,
  input  logic [DATA_WIDTH-1:0] multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [DATA_WIDTH-1:0] cur_acc, cur_mcand, cur_mplier, step_acc;
  logic [CW-1:0]         cnt_q;
  logic                  busy_q, done_q;

  // The start cycle consumes bit 0 straight from the inputs so that all
  // DATA_WIDTH iterations fit between the start edge and the done pulse.
  always_comb begin
    cur_acc    = start ? '0           : acc_q;
    cur_mcand  = start ? multiplicand : mcand_q;
    cur_mplier = start ? multiplier   : mplier_q;
    step_acc   = cur_acc + (cur_mplier[0] ? cur_mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q    <= step_acc;
        mcand_q  <= cur_mcand << 1;
        mplier_q <= cur_mplier >> 1;
        cnt_q    <= CW'(DATA_WIDTH - 1);
        busy_q   <= (DATA_WIDTH > 1);
        done_q   <= (DATA_WIDTH == 1);
      end else if (busy_q) begin
        acc_q    <= step_acc;
        mcand_q  <= cur_mcand << 1;
        mplier_q <= cur_mplier >> 1;
        cnt_q    <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// Purpose : multi-cycle ALU, one operation in flight, valid/ready on both sides.
// Latency : result valid 2 edges after accept (counting the accept edge), 33 for mul at 32 bits.
// Backpressure: result held in DONE until RES_READY; REQ_READY low whenever not IDLE.
//
// Ports: CLK, RST (sync, active-low); REQ_VALID/REQ_READY with OPRN, OP1, OP2;
//        RES_VALID/RES_READY with RESULT and ERR (illegal opcode).
module alu_mc #(
  parameter int DATA_WIDTH = alu_mc_pkg::DATA_WIDTH,
  parameter int OPRN_WIDTH = alu_mc_pkg::ALU_OPRN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [OPRN_WIDTH-1:0] OPRN,
  input  logic [DATA_WIDTH-1:0] OP1,
  input  logic [DATA_WIDTH-1:0] OP2,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  ERR
);

  import alu_mc_pkg::*;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [OPRN_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  err_q;

  logic                  accept;
  logic                  req_is_mul;
  logic                  mul_start;
  logic                  mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0] exec_res;
  logic                  exec_err;
  logic                  shift_oob;

  assign accept     = REQ_VALID && REQ_READY;
  assign req_is_mul = (OPRN == OPRN_WIDTH'(ALU_OPRN_MUL));
  assign mul_start  = accept && req_is_mul;

  // Multiplier takes operands directly from the request on the accept edge.
  mult_seq #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
    .clk          (CLK),
    .rst_n        (RST),
    .start        (mul_start),
    .multiplicand (OP1),
    .multiplier   (OP2),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = req_is_mul ? MUL : EXEC;
      EXEC: state_d = DONE;
      // busy is checked too so a stray done can never skip iterations
      MUL:  if (mul_done && !mul_busy) state_d = DONE;
      DONE: if (RES_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle datapath on the latched operands.
  always_comb begin
    shift_oob = (b_q >= SHIFT_LIMIT);
    exec_res  = '0;
    exec_err  = 1'b0;
    case (op_q)
      OPRN_WIDTH'(ALU_OPRN_ADD): exec_res = a_q + b_q;
      OPRN_WIDTH'(ALU_OPRN_SUB): exec_res = a_q - b_q;
      OPRN_WIDTH'(ALU_OPRN_SRL): exec_res = shift_oob ? '0 : (a_q >> b_q);
      OPRN_WIDTH'(ALU_OPRN_SLL): exec_res = shift_oob ? '0 : (a_q << b_q);
      OPRN_WIDTH'(ALU_OPRN_AND): exec_res = a_q & b_q;
      OPRN_WIDTH'(ALU_OPRN_OR):  exec_res = a_q | b_q;
      OPRN_WIDTH'(ALU_OPRN_NOR): exec_res = ~(a_q | b_q);
      OPRN_WIDTH'(ALU_OPRN_SLT): exec_res = {{(DATA_WIDTH-1){1'b0}}, (a_q < b_q)};
      default:                   exec_err = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= OPRN;
        a_q  <= OP1;
        b_q  <= OP2;
      end
      if (state_q == EXEC) begin
        result_q <= exec_res;
        err_q    <= exec_err;
      end else if (state_q == MUL && state_d == DONE) begin
        result_q <= mul_product;
        err_q    <= 1'b0;
      end
    end
  end

  // Gate with RST so no request is advertised while reset is held.
  assign REQ_READY = RST && (state_q == IDLE);
  assign RES_VALID = (state_q == DONE);
  assign RESULT    = result_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        RES_READY = 1'b0;
  logic [5:0]  OPRN = '0;
  logic [31:0] OP1 = '0;
  logic [31:0] OP2 = '0;
  wire         REQ_READY;
  wire         RES_VALID;
  wire         ERR;
  wire  [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  logic        exp_vld = 1'b0;
  logic [31:0] exp_res = '0;
  logic        exp_err = 1'b0;

  always #5 CLK = ~CLK;

  alu_mc #(.DATA_WIDTH(32), .OPRN_WIDTH(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .OPRN      (OPRN),
    .OP1       (OP1),
    .OP2       (OP2),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RESULT    (RESULT),
    .ERR       (ERR)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference behaviour written straight from the opcode table.
  task automatic model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    e = 1'b0;
    case (op)
      6'h01: r = a + b;
      6'h02: r = a - b;
      6'h03: r = p[31:0];
      6'h04: r = (b >= 32) ? 32'd0 : (a >> b);
      6'h05: r = (b >= 32) ? 32'd0 : (a << b);
      6'h06: r = a & b;
      6'h07: r = a | b;
      6'h08: r = ~(a | b);
      6'h09: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
  endtask

  // Every cycle a result is presented it must match the outstanding expectation.
  always @(negedge CLK) begin
    if (RST && RES_VALID) begin
      if (!exp_vld) begin
        check("spurious_res_valid", RES_VALID, 1'b0);
      end else begin
        check("result", RESULT, exp_res);
        check("err", ERR, exp_err);
        check("req_ready_in_done", REQ_READY, 1'b0);
      end
    end
  end

  // Issue one op from a negedge; scramble the request bus while busy; hold off
  // RES_READY for 'stall' cycles once the result appears.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r_exp, input logic e_exp, input int stall);
    int n;
    bit seen;
    int lat;
    n = 0;
    while (!REQ_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_idle", REQ_READY, 1'b1);
    exp_res = r_exp;
    exp_err = e_exp;
    exp_vld = 1'b1;
    OPRN = op; OP1 = a; OP2 = b;
    REQ_VALID = 1'b1;
    RES_READY = 1'($urandom_range(0, 1));
    lat = (op == 6'h03) ? 33 : 2;
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (RES_VALID) begin
        seen = 1'b1;
        REQ_VALID = 1'b0;
        RES_READY = 1'b0;
      end else begin
        check("req_ready_busy", REQ_READY, 1'b0);
        REQ_VALID = 1'($urandom_range(0, 1));
        OPRN = 6'($urandom);
        OP1 = $urandom;
        OP2 = $urandom;
        RES_READY = 1'($urandom_range(0, 1));
      end
    end
    check("latency", n, lat);
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("hold_valid", RES_VALID, 1'b1);
      check("hold_result", RESULT, r_exp);
    end
    RES_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RES_READY = 1'b0;
    exp_vld = 1'b0;
    check("valid_dropped", RES_VALID, 1'b0);
    check("ready_after_done", REQ_READY, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [5:0]  rop;
    logic [31:0] ra, rb, rr;
    logic        re;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_res_valid", RES_VALID, 1'b0);
    check("rst_result", RESULT, 32'd0);
    check("rst_err", ERR, 1'b0);
    check("rst_req_ready", REQ_READY, 1'b0);
    RST = 1'b1;
    #1;
    check("req_ready_release", REQ_READY, 1'b1);
    @(negedge CLK);

    // Directed, hand-computed expectations
    run_op(6'h01, 32'd15, 32'd3, 32'd18, 1'b0, 0);
    run_op(6'h02, 32'd15, 32'd5, 32'd10, 1'b0, 1);
    run_op(6'h03, 32'd3, 32'd3, 32'd9, 1'b0, 0);
    run_op(6'h03, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 2);
    run_op(6'h04, 32'd8, 32'd1, 32'd4, 1'b0, 0);
    run_op(6'h04, 32'd8, 32'd4, 32'd0, 1'b0, 0);
    run_op(6'h05, 32'd1, 32'd4, 32'd16, 1'b0, 0);
    run_op(6'h05, 32'd1, 32'd40, 32'd0, 1'b0, 0);
    run_op(6'h04, 32'hFFFF_FFFF, 32'd32, 32'd0, 1'b0, 0);
    run_op(6'h09, 32'd3, 32'd5, 32'd1, 1'b0, 0);
    run_op(6'h09, 32'd5, 32'd3, 32'd0, 1'b0, 0);
    run_op(6'h08, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(6'h06, 32'hF0, 32'h3C, 32'h30, 1'b0, 10);
    run_op(6'h02, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(6'h00, 32'd7, 32'd9, 32'd0, 1'b1, 0);
    run_op(6'h3F, 32'd7, 32'd9, 32'd0, 1'b1, 0);
    run_op(6'h07, 32'd1, 32'd2, 32'd3, 1'b0, 0);
    run_op(6'h05, 32'd1, 32'd4, 32'd16, 1'b0, 0);

    // Reset in the middle of a multiply
    OPRN = 6'h03; OP1 = 32'd1234; OP2 = 32'd5678;
    REQ_VALID = 1'b1;
    exp_vld = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    check("mul_started", REQ_READY, 1'b0);
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("abort_res_valid", RES_VALID, 1'b0);
    check("abort_result", RESULT, 32'd0);
    check("abort_err", ERR, 1'b0);
    check("abort_req_ready_low", REQ_READY, 1'b0);
    RST = 1'b1;
    #1;
    check("abort_req_ready_release", REQ_READY, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      check("abort_no_result", RES_VALID, 1'b0);
    end
    run_op(6'h01, 32'd2, 32'd2, 32'd4, 1'b0, 0);

    // Randomized traffic against the reference model
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 3) == 0) rop = 6'($urandom_range(0, 63));
      else                           rop = 6'($urandom_range(1, 9));
      ra = $urandom;
      rb = $urandom;
      if ((rop == 6'h04 || rop == 6'h05) && $urandom_range(0, 1) == 1)
        rb = 32'($urandom_range(0, 40));
      if (rop == 6'h09 && $urandom_range(0, 3) == 0) rb = ra;
      model_op(rop, ra, rb, rr, re);
      run_op(rop, ra, rb, rr, re, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), operand/result width.
REQ-002 SHALL have parameter OPRN_WIDTH, default `ALU_OPRN_WIDTH (6), opcode width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 REQ_VALID  input  1  request present on OPRN/OP1/OP2.
REQ-006 REQ_READY  output  1  block can accept a request this cycle.
REQ-007 OPRN  input  OPRN_WIDTH  opcode.
REQ-008 OP1, OP2  input  DATA_WIDTH each  operands, unsigned.
REQ-009 RES_VALID  output  1  RESULT/ERR valid.
REQ-010 RES_READY  input  1  consumer takes result.
REQ-011 RESULT  output  DATA_WIDTH  registered result.
REQ-012 ERR  output  1  illegal opcode flag, qualified by RES_VALID.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, MUL, DONE.
REQ-014 REQ_READY SHALL be 1 only in IDLE; accept = REQ_VALID & REQ_READY at a rising edge.
REQ-015 On accept SHALL latch OPRN, OP1, OP2; later input changes SHALL be ignored until the next accept.
REQ-016 On accept, opcode 0x03 -> MUL; any other opcode -> EXEC.
REQ-017 EXEC SHALL last one cycle, register RESULT/ERR, go to DONE; RES_VALID high 2 edges after the accept edge.
REQ-018 MUL SHALL be iterative shift-add, one multiplier bit per cycle, exactly DATA_WIDTH cycles, no early exit; RES_VALID high DATA_WIDTH+1 edges after accept (33 at default).
REQ-019 Opcodes: 0x01 add, 0x02 sub, 0x03 mul, 0x04 srl, 0x05 sll, 0x06 and, 0x07 or, 0x08 nor, 0x09 set-less-than.
REQ-020 add/sub/mul SHALL wrap modulo 2^DATA_WIDTH; mul returns the low DATA_WIDTH bits of the product.
REQ-021 Shifts SHALL be logical by the full unsigned OP2; OP2 >= DATA_WIDTH SHALL give 0.
REQ-022 Set-less-than SHALL be an unsigned compare, RESULT = 1 if OP1 < OP2, else 0.
REQ-023 Illegal opcode (0x00, 0x0A-0x3F) SHALL take EXEC, give RESULT=0, ERR=1; legal opcodes give ERR=0.
REQ-024 In DONE, RES_VALID=1 and RESULT/ERR SHALL stay stable until RES_READY=1 is sampled, then go to IDLE on that edge.
REQ-025 RES_READY outside DONE SHALL be ignored; REQ_VALID outside IDLE SHALL be ignored (not queued).
REQ-026 Minimum request spacing SHALL be 3 cycles (accept, EXEC, DONE with RES_READY=1); at most one operation in flight.

Reset
REQ-027 RST=0 at a rising edge SHALL force IDLE, RES_VALID=0, RESULT=0, ERR=0 and clear latched operands and multiplier state.
REQ-028 REQ_READY SHALL be 0 while RST=0 and 1 on the first cycle after reset release.
REQ-029 Reset in EXEC, MUL or DONE SHALL abort the operation with no result ever presented.

Structure
REQ-030 Opcode constants (ALU_OPRN_ADD..ALU_OPRN_SLT), DATA_WIDTH and ALU_OPRN_WIDTH SHALL live in prj_definition.v; FSM state encodings stay local.
REQ-031 The iterative multiplier SHALL be one sub-module, mult_seq (start, busy/done, product low word); all other datapath logic is inline.

Verification
REQ-032 Add 15+3 and sub 15-5: RESULT=18, then 10, ERR=0, RES_VALID exactly 2 edges after each accept.
REQ-033 Mul 3*3=9 and 0xFFFFFFFF*2=0xFFFFFFFE: RES_VALID exactly 33 edges after accept; REQ_READY=0 throughout; OP1 changed mid-MUL has no effect.
REQ-034 Shifts: 8>>1=4, 8>>4=0, 1<<4=16, 1<<40=0; SLT 3<5=1, 5<3=0; nor 0,0=0xFFFFFFFF.
REQ-035 Backpressure: hold RES_READY=0 for 10 cycles in DONE -> RESULT stable, REQ_READY=0; raise RES_READY -> IDLE next edge.
REQ-036 Reset: assert RST=0 at MUL cycle 10 -> next edge RES_VALID=0, RESULT=0, IDLE; a new 2+2 request then returns 4 with normal latency.
REQ-037 Opcode 0x00 and 0x3F: RESULT=0, ERR=1; the following legal op returns ERR=0.
